mem_access_unit: RTL and testbench

Initiator for the `DataMemory` port, sitting in the MEM stage between the pipeline and the data memory. It accepts one load/store request at a time over a valid/ready handshake and pre-checks alignment and range, raising MIPS AdEL/AdES itself. Legal requests are sequenced onto the memory's `addr/din/memWrite/memRead/memSize/memSign` port for a fixed number of cycles. The unit returns read data or an exception over a valid/ready response channel.

---
 rtl/mem_access_unit_if.sv | 61 ++++++
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//
// Groups the three buses around the MEM-stage access unit:
//   request  (pipeline -> unit): req_valid/req_ready handshake plus
//            req_write, req_size, req_sign, req_addr, req_wdata
//   response (unit -> pipeline): rsp_valid/rsp_ready handshake plus
//            rsp_rdata, rsp_exc, rsp_exc_code, rsp_badvaddr
//   memory   (unit <-> DataMemory): mem_addr, mem_din, mem_write, mem_read,
//            mem_size, mem_sign out; mem_dout, mem_exception back
//
// Modports:
//   slave  - the access unit itself
//   master - the surrounding environment (pipeline + data memory)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [4:0]  rsp_exc_code;
    logic [31:0] rsp_badvaddr;

    // data memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_dout;
    logic        mem_exception;

    modport slave (
        input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code, rsp_badvaddr,
        input  rsp_ready,
        output mem_addr, mem_din, mem_write, mem_read, mem_size, mem_sign,
        input  mem_dout, mem_exception
    );

    modport master (
        output req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code, rsp_badvaddr,
        output rsp_ready,
        input  mem_addr, mem_din, mem_write, mem_read, mem_size, mem_sign,
        output mem_dout, mem_exception
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage initiator for the DataMemory port. Accepts one load/store at a
// time, pre-checks size/alignment/range (raising MIPS AdEL=4 / AdES=5 without
// touching memory), otherwise drives the memory port for MEM_LATENCY cycles,
// samples the read data / memory exception on the last of those cycles and
// returns the result on a valid/ready response channel.
//
// Parameters:
//   MEM_LATENCY - cycles the access is held on the memory port (1..15)
//   ADDR_LIMIT  - first illegal byte address
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous, active-low reset
//   bus - mem_access_unit_if.slave (request, response and memory buses)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] ADDR_LIMIT  = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter counts down from MEM_LATENCY-1; the access finishes when it is 0.
    localparam logic [3:0]  CNT_LOAD  = 4'(MEM_LATENCY - 1);
    localparam logic [32:0] LIMIT_EXT = {1'b0, ADDR_LIMIT};

    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        write_reg, write_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] din_reg, din_next;
    logic [1:0]  size_reg, size_next;
    logic        sign_reg, sign_next;

    logic [31:0] rdata_reg, rdata_next;
    logic        exc_reg, exc_next;
    logic [4:0]  code_reg, code_next;
    logic [31:0] badvaddr_reg, badvaddr_next;

    // -----------------------------------------------------------------------
    // Accept-time fault detection
    // -----------------------------------------------------------------------
    logic [2:0]  span;          // bytes in the access minus one
    logic        size_bad;
    logic        align_bad;
    logic        range_bad;
    logic        req_fault;
    logic [32:0] last_byte;

    always_comb begin
        span      = 3'd0;
        size_bad  = 1'b0;
        align_bad = 1'b0;
        case (bus.req_size)
            2'b00: span = 3'd0;
            2'b01: begin
                span      = 3'd1;
                align_bad = bus.req_addr[0];
            end
            2'b10: begin
                span      = 3'd3;
                align_bad = |bus.req_addr[1:0];
            end
            default: size_bad = 1'b1;
        endcase
        // 33-bit sum so an access that wraps past 32'hFFFF_FFFF still lands
        // above the limit instead of wrapping back into range.
        last_byte = {1'b0, bus.req_addr} + {30'd0, span};
        range_bad = (last_byte >= LIMIT_EXT);
        req_fault = size_bad | align_bad | range_bad;
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            write_reg    <= 1'b0;
            addr_reg     <= 32'd0;
            din_reg      <= 32'd0;
            size_reg     <= 2'b00;
            sign_reg     <= 1'b0;
            rdata_reg    <= 32'd0;
            exc_reg      <= 1'b0;
            code_reg     <= 5'd0;
            badvaddr_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            write_reg    <= write_next;
            addr_reg     <= addr_next;
            din_reg      <= din_next;
            size_reg     <= size_next;
            sign_reg     <= sign_next;
            rdata_reg    <= rdata_next;
            exc_reg      <= exc_next;
            code_reg     <= code_next;
            badvaddr_reg <= badvaddr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        write_next    = write_reg;
        addr_next     = addr_reg;
        din_next      = din_reg;
        size_next     = size_reg;
        sign_next     = sign_reg;
        rdata_next    = rdata_reg;
        exc_next      = exc_reg;
        code_next     = code_reg;
        badvaddr_next = badvaddr_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_fault) begin
                        // Unit-raised address error: straight to the
                        // response, memory port registers left untouched.
                        state_next    = RESP;
                        rdata_next    = 32'd0;
                        exc_next      = 1'b1;
                        code_next     = bus.req_write ? CODE_ADES : CODE_ADEL;
                        badvaddr_next = bus.req_addr;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = CNT_LOAD;
                        write_next = bus.req_write;
                        addr_next  = bus.req_addr;
                        din_next   = bus.req_wdata;
                        size_next  = bus.req_size;
                        sign_next  = bus.req_sign;
                    end
                end
            end

            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    if (bus.mem_exception) begin
                        rdata_next    = 32'd0;
                        exc_next      = 1'b1;
                        code_next     = write_reg ? CODE_ADES : CODE_ADEL;
                        badvaddr_next = addr_reg;
                    end else begin
                        rdata_next    = write_reg ? 32'd0 : bus.mem_dout;
                        exc_next      = 1'b0;
                        code_next     = 5'd0;
                        badvaddr_next = 32'd0;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready    = (state_reg == IDLE);
    assign bus.rsp_valid    = (state_reg == RESP);
    assign bus.rsp_rdata    = rdata_reg;
    assign bus.rsp_exc      = exc_reg;
    assign bus.rsp_exc_code = code_reg;
    assign bus.rsp_badvaddr = badvaddr_reg;

    // Strobes decode straight from the state register so the asynchronous
    // reset drops them immediately. A store writes only on the first ACCESS
    // cycle (counter still at its load value); a load reads throughout.
    assign bus.mem_read  = (state_reg == ACCESS) && !write_reg;
    assign bus.mem_write = (state_reg == ACCESS) && write_reg && (cnt_reg == CNT_LOAD);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_din   = din_reg;
    assign bus.mem_size  = size_reg;
    assign bus.mem_sign  = sign_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two units share one clock and reset: unit 0 with MEM_LATENCY=1, unit 1 with
// MEM_LATENCY=3. Each unit has its own little-endian byte-addressed memory
// model behind its memory port.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic clk;
    logic rst;

    // per-unit stimulus
    logic        req_valid [2];
    logic        req_write [2];
    logic [1:0]  req_size  [2];
    logic        req_sign  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_ready [2];
    logic        mem_exc   [2];

    // per-unit observations
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_exc   [2];
    logic [4:0]  rsp_code  [2];
    logic [31:0] rsp_bad   [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_din   [2];
    logic        mem_write [2];
    logic        mem_read  [2];
    logic [1:0]  mem_size  [2];
    logic        mem_sign  [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        mem_access_unit_if bus ();

        mem_access_unit #(
            .MEM_LATENCY(gi == 0 ? 1 : 3),
            .ADDR_LIMIT (32'h0000_1000)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        assign bus.req_valid     = req_valid[gi];
        assign bus.req_write     = req_write[gi];
        assign bus.req_size      = req_size[gi];
        assign bus.req_sign      = req_sign[gi];
        assign bus.req_addr      = req_addr[gi];
        assign bus.req_wdata     = req_wdata[gi];
        assign bus.rsp_ready     = rsp_ready[gi];
        assign bus.mem_exception = mem_exc[gi];

        assign req_ready[gi] = bus.req_ready;
        assign rsp_valid[gi] = bus.rsp_valid;
        assign rsp_rdata[gi] = bus.rsp_rdata;
        assign rsp_exc[gi]   = bus.rsp_exc;
        assign rsp_code[gi]  = bus.rsp_exc_code;
        assign rsp_bad[gi]   = bus.rsp_badvaddr;
        assign mem_addr[gi]  = bus.mem_addr;
        assign mem_din[gi]   = bus.mem_din;
        assign mem_write[gi] = bus.mem_write;
        assign mem_read[gi]  = bus.mem_read;
        assign mem_size[gi]  = bus.mem_size;
        assign mem_sign[gi]  = bus.mem_sign;

        // Little-endian byte memory, 4 KiB, combinational read.
        logic [7:0]  mem [4096];
        logic [11:0] ma;
        logic [31:0] raw;
        assign ma  = bus.mem_addr[11:0];
        assign raw = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

        always_comb begin
            case (bus.mem_size)
                2'b00:   bus.mem_dout = {{24{bus.mem_sign & raw[7]}}, raw[7:0]};
                2'b01:   bus.mem_dout = {{16{bus.mem_sign & raw[15]}}, raw[15:0]};
                default: bus.mem_dout = raw;
            endcase
        end

        always @(posedge clk) begin
            if (bus.mem_write) begin
                mem[ma] <= bus.mem_din[7:0];
                if (bus.mem_size != 2'b00) mem[ma + 12'd1] <= bus.mem_din[15:8];
                if (bus.mem_size == 2'b10) begin
                    mem[ma + 12'd2] <= bus.mem_din[23:16];
                    mem[ma + 12'd3] <= bus.mem_din[31:24];
                end
            end
        end
    end

    // results of the most recent transaction
    logic [31:0] r_rdata;
    logic        r_exc;
    logic [4:0]  r_code;
    logic [31:0] r_bad;
    int          r_wc;
    int          r_rc;
    int          r_lat;
    logic        r_busy;
    logic        r_stable;
    logic        r_rdy_after;
    logic        r_vld_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request/response transaction on unit u. lat counts negedges from
    // accept until rsp_valid is seen (inclusive). hold = extra cycles with
    // rsp_ready low; spam keeps a store request asserted while busy.
    task automatic do_txn(input int u, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input logic spam);
        @(negedge clk);
        req_write[u] = wr;
        req_size[u]  = sz;
        req_sign[u]  = sg;
        req_addr[u]  = a;
        req_wdata[u] = wd;
        req_valid[u] = 1'b1;
        r_wc = 0; r_rc = 0; r_lat = 0; r_busy = 1'b0; r_stable = 1'b1;
        do begin
            @(negedge clk);
            if (spam) req_write[u] = 1'b1;
            else      req_valid[u] = 1'b0;
            r_wc   += int'(mem_write[u]);
            r_rc   += int'(mem_read[u]);
            r_busy |= req_ready[u];
            r_lat++;
        end while (!rsp_valid[u] && r_lat < 40);
        r_rdata = rsp_rdata[u];
        r_exc   = rsp_exc[u];
        r_code  = rsp_code[u];
        r_bad   = rsp_bad[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid[u] || rsp_rdata[u] !== r_rdata || rsp_exc[u] !== r_exc)
                r_stable = 1'b0;
            r_wc   += int'(mem_write[u]);
            r_rc   += int'(mem_read[u]);
            r_busy |= req_ready[u];
        end
        req_valid[u] = 1'b0;
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        r_rdy_after  = req_ready[u];
        r_vld_after  = rsp_valid[u];
        $display("txn u%0d wr=%0b size=%0d sign=%0b addr=%h wdata=%h -> rdata=%h exc=%0b code=%0d bad=%h lat=%0d wr_cyc=%0d rd_cyc=%0d",
                 u, wr, sz, sg, a, wd, r_rdata, r_exc, r_code, r_bad, r_lat, r_wc, r_rc);
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic exc,
                              input logic [4:0] code, input logic [31:0] bad, input int lat);
        chk({tag, ".rdata"}, r_rdata, rdata);
        chk({tag, ".exc"},   32'(r_exc), 32'(exc));
        chk({tag, ".code"},  32'(r_code), 32'(code));
        chk({tag, ".bad"},   r_bad, bad);
        chk({tag, ".lat"},   r_lat, lat);
        chk({tag, ".busy_ready"}, 32'(r_busy), 32'd0);
        chk({tag, ".ready_after"}, 32'(r_rdy_after), 32'd1);
        chk({tag, ".valid_after"}, 32'(r_vld_after), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_write[u] = 1'b0; req_size[u] = 2'b00;
            req_sign[u]  = 1'b0; req_addr[u]  = 32'd0; req_wdata[u] = 32'd0;
            rsp_ready[u] = 1'b0; mem_exc[u]   = 1'b0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        // reset values
        chk("rst.req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst.rsp_exc",   32'(rsp_exc[0]),   32'd0);
        chk("rst.rsp_code",  32'(rsp_code[0]),  32'd0);
        chk("rst.rsp_rdata", rsp_rdata[0],      32'd0);
        chk("rst.rsp_bad",   rsp_bad[0],        32'd0);
        chk("rst.mem_write", 32'(mem_write[0]), 32'd0);
        chk("rst.mem_read",  32'(mem_read[0]),  32'd0);
        chk("rst.mem_size",  32'(mem_size[0]),  32'd0);
        chk("rst.mem_sign",  32'(mem_sign[0]),  32'd0);
        chk("rst.mem_addr",  mem_addr[0],       32'd0);
        chk("rst.mem_din",   mem_din[0],        32'd0);
        chk("rst.u1_ready",  32'(req_ready[1]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // store round trip, L=1
        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b0);
        expect_rsp("sw0", 32'h0, 1'b0, 5'd0, 32'h0, 2);
        chk("sw0.wr_cyc", r_wc, 1); chk("sw0.rd_cyc", r_rc, 0);
        do_txn(0, 1'b1, 2'b01, 1'b0, 32'h4, 32'h1234_5678, 0, 1'b0);
        expect_rsp("sh4", 32'h0, 1'b0, 5'd0, 32'h0, 2);
        chk("sh4.wr_cyc", r_wc, 1);
        do_txn(0, 1'b1, 2'b00, 1'b0, 32'h6, 32'hFFFF_FFFF, 0, 1'b0);
        expect_rsp("sb6", 32'h0, 1'b0, 5'd0, 32'h0, 2);
        chk("sb6.wr_cyc", r_wc, 1);
        do_txn(0, 1'b1, 2'b00, 1'b0, 32'h7, 32'hEEEE_EEEE, 0, 1'b0);
        expect_rsp("sb7", 32'h0, 1'b0, 5'd0, 32'h0, 2);
        chk("sb7.wr_cyc", r_wc, 1);

        // loads
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        expect_rsp("lw0", 32'h1234_5678, 1'b0, 5'd0, 32'h0, 2);
        chk("lw0.rd_cyc", r_rc, 1); chk("lw0.wr_cyc", r_wc, 0);
        do_txn(0, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 0, 1'b0);
        expect_rsp("lh6", 32'hFFFF_EEFF, 1'b0, 5'd0, 32'h0, 2);
        do_txn(0, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 0, 1'b0);
        expect_rsp("lhu6", 32'h0000_EEFF, 1'b0, 5'd0, 32'h0, 2);
        do_txn(0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        expect_rsp("lb0", 32'h0000_0078, 1'b0, 5'd0, 32'h0, 2);
        do_txn(0, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 0, 1'b0);
        expect_rsp("lb7", 32'hFFFF_FFEE, 1'b0, 5'd0, 32'h0, 2);

        // misaligned / reserved size
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 0, 1'b0);
        expect_rsp("lw3", 32'h0, 1'b1, 5'd4, 32'h3, 1);
        chk("lw3.rd_cyc", r_rc, 0);
        do_txn(0, 1'b1, 2'b01, 1'b0, 32'h5, 32'hABCD, 0, 1'b0);
        expect_rsp("sh5", 32'h0, 1'b1, 5'd5, 32'h5, 1);
        chk("sh5.wr_cyc", r_wc, 0);
        do_txn(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        expect_rsp("l_sz3", 32'h0, 1'b1, 5'd4, 32'h10, 1);
        do_txn(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        expect_rsp("s_sz3", 32'h0, 1'b1, 5'd5, 32'h10, 1);
        chk("s_sz3.wr_cyc", r_wc, 0);

        // range boundary
        do_txn(0, 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hD4C3_B2A1, 0, 1'b0);
        expect_rsp("swFFC", 32'h0, 1'b0, 5'd0, 32'h0, 2);
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 0, 1'b0);
        expect_rsp("lwFFC", 32'hD4C3_B2A1, 1'b0, 5'd0, 32'h0, 2);
        do_txn(0, 1'b0, 2'b01, 1'b1, 32'hFFE, 32'h0, 0, 1'b0);
        expect_rsp("lhFFE", 32'hFFFF_D4C3, 1'b0, 5'd0, 32'h0, 2);
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
        expect_rsp("lw1000", 32'h0, 1'b1, 5'd4, 32'h1000, 1);
        chk("lw1000.rd_cyc", r_rc, 0);
        do_txn(0, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
        expect_rsp("lbFFFFFFFF", 32'h0, 1'b1, 5'd4, 32'hFFFF_FFFF, 1);

        // memory-raised exception
        mem_exc[0] = 1'b1;
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, 1'b0);
        expect_rsp("lw8_mexc", 32'h0, 1'b1, 5'd4, 32'h8, 2);
        chk("lw8_mexc.rd_cyc", r_rc, 1);
        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h5555_5555, 0, 1'b0);
        expect_rsp("sw8_mexc", 32'h0, 1'b1, 5'd5, 32'h8, 2);
        mem_exc[0] = 1'b0;

        // reset during ACCESS of a load
        @(negedge clk);
        req_write[0] = 1'b0; req_size[0] = 2'b10; req_sign[0] = 1'b0;
        req_addr[0]  = 32'h8; req_valid[0] = 1'b1;
        @(posedge clk);
        #2;
        req_valid[0] = 1'b0;
        chk("mid.pre_read", 32'(mem_read[0]), 32'd1);
        chk("mid.pre_addr", mem_addr[0], 32'h8);
        rst = 1'b0;
        #1;
        chk("mid.read",      32'(mem_read[0]),  32'd0);
        chk("mid.write",     32'(mem_write[0]), 32'd0);
        chk("mid.addr",      mem_addr[0],       32'd0);
        chk("mid.req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post.req_ready", 32'(req_ready[0]), 32'd1);
        chk("post.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        do_txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        expect_rsp("post.lw0", 32'h1234_5678, 1'b0, 5'd0, 32'h0, 2);

        // latency 3 and backpressure on unit 1
        do_txn(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 0, 1'b0);
        expect_rsp("u1.sw10", 32'h0, 1'b0, 5'd0, 32'h0, 4);
        chk("u1.sw10.wr_cyc", r_wc, 1);
        do_txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b1);
        expect_rsp("u1.lw10_bp", 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 4);
        chk("u1.lw10_bp.rd_cyc", r_rc, 3);
        chk("u1.lw10_bp.wr_cyc", r_wc, 0);
        chk("u1.lw10_bp.stable", 32'(r_stable), 32'd1);

        // rsp_ready while nothing is pending
        rsp_ready[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk("u1.idle_rdy.valid", 32'(rsp_valid[1]), 32'd0);
        chk("u1.idle_rdy.ready", 32'(req_ready[1]), 32'd1);
        rsp_ready[1] = 1'b0;

        do_txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        expect_rsp("u1.lw10", 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 4);
        chk("u1.lw10.rd_cyc", r_rc, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
